mos_timer_bank: RTL and testbench
=================================

# mos_timer_bank

Parametrised multi-channel interval timer with shared interrupt control; successor to the single-pair CIA timer logic for designs that need more channels, wider counters and arbitrary cascading. Sits on the 8-bit CPU bus beside the I/O chips, counts on `phi2` enable cycles, CNT edges or the previous channel's underflow, and drives per-channel timer outputs and one open-drain-style `irq_n`.

## Interface
- `CHANNELS`, 3: timer channels, 1..7.
- `WIDTH`, 16: counter width in bits, one of 8/16/24/32.
- `ADDR_W`, 5: register address width; must satisfy 2^ADDR_W > CHANNELS*8.
- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-high reset.
- `phi2` in 1: one-`clk` strobe per CPU cycle; all counting happens on `clk` edges where `phi2`=1.
- `cs_n` in 1: chip select, low for exactly one `clk` per access.
- `rw` in 1: 1 = read, 0 = write.
- `rs` in ADDR_W: register select.
- `db_in` in 8: write data.
- `db_out` out 8: registered read data.
- `cnt_in` in 1: external count input, already synchronised.
- `tmr_out` out CHANNELS: per-channel pulse/toggle output.
- `irq_n` out 1: interrupt request, active low.

## Operation
- Address map: channel i at base 8i. Offsets 0..WIDTH/8-1: read = live counter byte (LSB at 0), write = latch byte. Offset 4 = control. Unused offsets read 0, writes ignored. ICR at CHANNELS*8. Other addresses read 0.
- Control bits: [0] start; [1] output enable; [2] 1 = toggle, 0 = pulse; [3] one-shot; [4] force-load strobe (always reads 0); [6:5] source: 00 `phi2`, 01 `cnt_in` rising edge, 10 underflow of channel i-1, 11 underflow of i-1 while `cnt_in`=1; [7] reads 0. Sources 10/11 on channel 0 never count.
- Tick = `phi2` & start & source condition. On tick: counter≠0 → decrement; counter=0 → underflow: reload from latch, set pending[i], pulse/toggle output; one-shot clears start. Period = latch+1 ticks; latch 0 underflows every tick.
- Writing the most-significant latch byte with start=0 loads counter from latch. Force load loads counter on the next `phi2` cycle; it overrides a same-cycle decrement.
- Cascade: channel i-1 underflow ticks channel i in the same `phi2` cycle; chains of any length resolve combinationally in one cycle.
- Output: pulse mode drives `tmr_out[i]`=1 for the `phi2` cycle following underflow; toggle mode flips on underflow and is forced to 1 when start goes 0→1 by write. Output enable 0 → `tmr_out[i]`=0.
- ICR write: bit7=1 sets mask bits given in [6:0], bit7=0 clears them. ICR read returns {~irq_n, pending[6:0]} (bits ≥CHANNELS are 0), then clears pending and releases `irq_n`.
- `irq_n`=0 while (pending & mask)≠0. Underflow coincident with ICR read: old value is returned, the new bit stays set and `irq_n` reasserts next `clk`.
- Reset: counters 0, latches all-ones, control 0, mask 0, pending 0, `db_out` 0, `tmr_out` 0, `irq_n` 1. Reset mid-count aborts immediately; no underflow is reported.

## Timing
- Read: `db_out` valid on the `clk` edge after the access `clk`; held until next read.
- Write: register updated at the access `clk` edge; a control write at a `phi2` edge takes effect from the next `phi2` cycle.
- Underflow → pending set and `irq_n` low on the same `clk` edge as the reload.
- `cnt_in` edge detected between consecutive `phi2` samples; tick lands one `phi2` cycle after the edge sample.

## Configuration
- `TIMER_SNAPSHOT_EN` defined: reading a channel's most-significant counter byte copies the whole counter into a per-channel snapshot and freezes it; lower-byte reads return the snapshot; reading byte 0 releases the freeze. Undefined: all counter reads are live; no snapshot registers.

## Test plan
- Latch 0x0004, source `phi2`, start, mask ch0 → underflow every 5 `phi2` cycles; pending[0], `irq_n`=0; ICR read returns 0x81 and `irq_n`=1 next `clk`.
- One-shot, latch 0x0002 → single underflow after 3 ticks, control[0] reads 0, counter reloaded to 0x0002 and holds.
- Ch0 latch 1, ch1 source 10, latch 2 → ch1 underflows every 6 `phi2` cycles, same cycle as every third ch0 underflow.
- Toggle mode, output enable → `tmr_out[0]` goes 1 at start, flips each underflow; pulse mode gives single-cycle 1s.
- Underflow coincident with ICR read → read returns old pending, new bit still set, `irq_n` low next `clk`.
- `TIMER_SNAPSHOT_EN`: counter 0x0100 decrementing; read MSB (0x01), wait 3 ticks, read LSB → 0x00, not live value.

Source files
------------

// File: rtl/mos_timer_bank_if.sv
// CPU bus bundle for mos_timer_bank: chip select, direction, register select and data.
interface mos_timer_bank_if #(
    parameter int ADDR_W = 5
);
    logic              cs_n;
    logic              rw;
    logic [ADDR_W-1:0] rs;
    logic [7:0]        db_in;
    logic [7:0]        db_out;

    modport master (output cs_n, rw, rs, db_in, input db_out);
    modport slave  (input cs_n, rw, rs, db_in, output db_out);
endinterface

// File: rtl/mos_timer_bank.sv
// Multi-channel cascadable interval timer bank with shared interrupt control.
// Optional feature macro TIMER_SNAPSHOT_EN: read-freeze snapshot of multi-byte counters.
module mos_timer_bank #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                phi2,
    input  logic                cnt_in,
    mos_timer_bank_if.slave     bus,
    output logic [CHANNELS-1:0] tmr_out,
    output logic                irq_n
);

    localparam int                NBYTES   = WIDTH / 8;
    localparam logic [2:0]        MSB_OFF  = 3'(NBYTES - 1);
    localparam logic [2:0]        CTRL_OFF = 3'd4;
    localparam logic [ADDR_W-1:0] ICR_ADDR = ADDR_W'(CHANNELS * 8);

    logic [CHANNELS-1:0][WIDTH-1:0] counter;
    logic [CHANNELS-1:0][WIDTH-1:0] latch;
    logic [CHANNELS-1:0][WIDTH-1:0] latch_nxt;
    logic [CHANNELS-1:0][WIDTH-1:0] cnt_view;
    logic [CHANNELS-1:0][1:0]       src;
    logic [CHANNELS-1:0]            start, oe, tgl, one_shot, force_ld, out_q;
    logic [CHANNELS-1:0]            pending, mask;
    logic [CHANNELS-1:0]            tick, uf, ch_hit, ctrl_wr, ld_now;
    logic                           cnt_s, cnt_edge, prev_uf, cond;
    logic [ADDR_W-4:0]              ch_sel;
    logic [2:0]                     off;
    logic                           bus_wr, bus_rd, icr_hit, icr_wr, icr_rd;
    logic [7:0]                     rd_data;

    assign ch_sel  = bus.rs[ADDR_W-1:3];
    assign off     = bus.rs[2:0];
    assign bus_wr  = ~bus.cs_n & ~bus.rw;
    assign bus_rd  = ~bus.cs_n & bus.rw;
    assign icr_hit = (bus.rs == ICR_ADDR);
    assign icr_wr  = bus_wr & icr_hit;
    assign icr_rd  = bus_rd & icr_hit;

    assign irq_n   = ~|(pending & mask);
    assign tmr_out = out_q & oe;

    always_comb begin
        ch_hit    = '0;
        ctrl_wr   = '0;
        ld_now    = '0;
        latch_nxt = latch;
        for (int i = 0; i < CHANNELS; i++) begin
            ch_hit[i]  = (int'(ch_sel) == i);
            ctrl_wr[i] = bus_wr & ch_hit[i] & (off == CTRL_OFF);
            ld_now[i]  = bus_wr & ch_hit[i] & (off == MSB_OFF) & ~start[i];
            for (int b = 0; b < NBYTES; b++) begin
                if (bus_wr && ch_hit[i] && off == 3'(b))
                    latch_nxt[i][8*b +: 8] = bus.db_in;
            end
        end
    end

    // Walk channels in order so a cascade chain of any length settles in one pass.
    always_comb begin
        tick    = '0;
        uf      = '0;
        prev_uf = 1'b0;
        cond    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (src[i])
                2'b00:   cond = 1'b1;
                2'b01:   cond = cnt_edge;
                2'b10:   cond = prev_uf;
                default: cond = prev_uf & cnt_in;
            endcase
            tick[i] = phi2 & start[i] & cond;
            uf[i]   = tick[i] & (counter[i] == '0);
            prev_uf = uf[i];
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    logic [CHANNELS-1:0][WIDTH-1:0] snap;
    logic [CHANNELS-1:0]            frozen;

    always_comb begin
        cnt_view = counter;
        for (int i = 0; i < CHANNELS; i++) begin
            if (frozen[i] && off != MSB_OFF)
                cnt_view[i] = snap[i];
        end
    end

    // MSB read captures the whole counter; the byte-0 read ends the freeze.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap   <= '0;
            frozen <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus_rd && ch_hit[i]) begin
                    if (off == MSB_OFF && MSB_OFF != 3'd0) begin
                        snap[i]   <= counter[i];
                        frozen[i] <= 1'b1;
                    end else if (off == 3'd0) begin
                        frozen[i] <= 1'b0;
                    end
                end
            end
        end
    end
`else
    assign cnt_view = counter;
`endif

    always_comb begin
        rd_data = '0;
        if (icr_hit)
            rd_data = {~irq_n, 7'(pending)};
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_hit[i]) begin
                if (off == CTRL_OFF)
                    rd_data = {1'b0, src[i], 1'b0, one_shot[i], tgl[i], oe[i], start[i]};
                for (int b = 0; b < NBYTES; b++) begin
                    if (off == 3'(b))
                        rd_data = cnt_view[i][8*b +: 8];
                end
            end
        end
    end

    // Counter priority: MSB-latch load, force load, underflow reload, decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter    <= '0;
            latch      <= '1;
            src        <= '0;
            start      <= '0;
            oe         <= '0;
            tgl        <= '0;
            one_shot   <= '0;
            force_ld   <= '0;
            out_q      <= '0;
            pending    <= '0;
            mask       <= '0;
            cnt_s      <= 1'b0;
            cnt_edge   <= 1'b0;
            bus.db_out <= 8'h00;
        end else begin
            if (phi2) begin
                cnt_s    <= cnt_in;
                cnt_edge <= cnt_in & ~cnt_s;
            end
            if (bus_rd)
                bus.db_out <= rd_data;
            latch <= latch_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                if (ld_now[i])
                    counter[i] <= latch_nxt[i];
                else if (phi2 && force_ld[i])
                    counter[i] <= latch[i];
                else if (uf[i])
                    counter[i] <= latch[i];
                else if (tick[i])
                    counter[i] <= counter[i] - 1'b1;

                if (ctrl_wr[i] && bus.db_in[4])
                    force_ld[i] <= 1'b1;
                else if (phi2)
                    force_ld[i] <= 1'b0;

                if (ctrl_wr[i]) begin
                    start[i]    <= bus.db_in[0];
                    oe[i]       <= bus.db_in[1];
                    tgl[i]      <= bus.db_in[2];
                    one_shot[i] <= bus.db_in[3];
                    src[i]      <= bus.db_in[6:5];
                end else if (uf[i] && one_shot[i]) begin
                    start[i] <= 1'b0;
                end

                if (ctrl_wr[i] && bus.db_in[0] && !start[i] && bus.db_in[2])
                    out_q[i] <= 1'b1;
                else if (phi2) begin
                    if (tgl[i])
                        out_q[i] <= out_q[i] ^ uf[i];
                    else
                        out_q[i] <= uf[i];
                end

                pending[i] <= (pending[i] & ~icr_rd) | uf[i];

                if (icr_wr && bus.db_in[i])
                    mask[i] <= bus.db_in[7];
            end
        end
    end

endmodule

// File: tb/tb_mos_timer_bank.sv
// Directed self-checking bench for mos_timer_bank (3 channels, 16-bit, 5-bit address).
module tb_mos_timer_bank;
    logic       clk = 1'b0;
    logic       reset, phi2, cnt_in;
    logic [2:0] tmr_out;
    logic       irq_n;
    logic [7:0] d;
    int         n_checks = 0;
    int         n_pass = 0;

    localparam logic [4:0] ICR = 5'h18;

    mos_timer_bank_if #(.ADDR_W(5)) bus ();

    mos_timer_bank #(.CHANNELS(3), .WIDTH(16), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .phi2(phi2), .cnt_in(cnt_in),
        .bus(bus), .tmr_out(tmr_out), .irq_n(irq_n)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input logic p);
        phi2 = p;
        @(posedge clk); #1;
        phi2 = 1'b0;
    endtask

    task automatic phi_cycles(input int n);
        repeat (n) begin step(1'b1); step(1'b0); end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] v);
        bus.cs_n = 1'b0; bus.rw = 1'b0; bus.rs = a; bus.db_in = v;
        @(posedge clk); #1;
        bus.cs_n = 1'b1; bus.rw = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] v);
        bus.cs_n = 1'b0; bus.rw = 1'b1; bus.rs = a;
        @(posedge clk); #1;
        bus.cs_n = 1'b1;
        v = bus.db_out;
    endtask

    task automatic rd_phi(input logic [4:0] a, output logic [7:0] v);
        phi2 = 1'b1; bus.cs_n = 1'b0; bus.rw = 1'b1; bus.rs = a;
        @(posedge clk); #1;
        phi2 = 1'b0; bus.cs_n = 1'b1;
        v = bus.db_out;
    endtask

    task automatic do_reset();
        reset = 1'b1; phi2 = 1'b0; cnt_in = 1'b0;
        bus.cs_n = 1'b1; bus.rw = 1'b1; bus.rs = '0; bus.db_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (irq_n !== 1'b1) $display("[TB] FAIL reset_irq: got %b want 1", irq_n); else n_pass++;
        n_checks++; if (tmr_out !== 3'b000) $display("[TB] FAIL reset_tmr: got %b want 000", tmr_out); else n_pass++;
        n_checks++; if (bus.db_out !== 8'h00) $display("[TB] FAIL reset_dbout: got %h want 00", bus.db_out); else n_pass++;
        rd(5'h00, d); n_checks++; if (d !== 8'h00) $display("[TB] FAIL reset_cnt_lo: got %h want 00", d); else n_pass++;
        rd(5'h04, d); n_checks++; if (d !== 8'h00) $display("[TB] FAIL reset_ctrl: got %h want 00", d); else n_pass++;
        rd(ICR, d);   n_checks++; if (d !== 8'h00) $display("[TB] FAIL reset_icr: got %h want 00", d); else n_pass++;
        wr(5'h10 + 5'h05, 8'hAA);
        rd(5'h15, d); n_checks++; if (d !== 8'h00) $display("[TB] FAIL unused_off: got %h want 00", d); else n_pass++;
        rd(5'h1F, d); n_checks++; if (d !== 8'h00) $display("[TB] FAIL unused_addr: got %h want 00", d); else n_pass++;
        // Force load copies the reset latch value (all ones) into the counter.
        wr(5'h04, 8'h10);
        step(1'b1);
        rd(5'h00, d); n_checks++; if (d !== 8'hFF) $display("[TB] FAIL force_lo: got %h want FF", d); else n_pass++;
        rd(5'h01, d); n_checks++; if (d !== 8'hFF) $display("[TB] FAIL force_hi: got %h want FF", d); else n_pass++;
        rd(5'h04, d); n_checks++; if (d !== 8'h00) $display("[TB] FAIL force_ctrl: got %h want 00", d); else n_pass++;
    endtask

    task automatic test_periodic();
        do_reset();
        wr(5'h00, 8'h04); wr(5'h01, 8'h00); wr(ICR, 8'h81); wr(5'h04, 8'h01);
        phi_cycles(4);
        rd(5'h00, d); n_checks++; if (d !== 8'h00) $display("[TB] FAIL per_cnt0: got %h want 00", d); else n_pass++;
        n_checks++; if (irq_n !== 1'b1) $display("[TB] FAIL per_irq_pre: got %b want 1", irq_n); else n_pass++;
        step(1'b1);
        n_checks++; if (irq_n !== 1'b0) $display("[TB] FAIL per_irq_uf: got %b want 0", irq_n); else n_pass++;
        rd(5'h00, d); n_checks++; if (d !== 8'h04) $display("[TB] FAIL per_reload: got %h want 04", d); else n_pass++;
        rd(ICR, d);   n_checks++; if (d !== 8'h81) $display("[TB] FAIL per_icr: got %h want 81", d); else n_pass++;
        n_checks++; if (irq_n !== 1'b1) $display("[TB] FAIL per_irq_clr: got %b want 1", irq_n); else n_pass++;
        rd(ICR, d);   n_checks++; if (d !== 8'h00) $display("[TB] FAIL per_icr2: got %h want 00", d); else n_pass++;
        phi_cycles(4);
        n_checks++; if (irq_n !== 1'b1) $display("[TB] FAIL per_irq_pre2: got %b want 1", irq_n); else n_pass++;
        step(1'b1);
        n_checks++; if (irq_n !== 1'b0) $display("[TB] FAIL per_irq_uf2: got %b want 0", irq_n); else n_pass++;
    endtask

    task automatic test_one_shot();
        do_reset();
        wr(5'h00, 8'h02); wr(5'h01, 8'h00); wr(5'h04, 8'h09);
        phi_cycles(3);
        rd(5'h04, d); n_checks++; if (d !== 8'h08) $display("[TB] FAIL os_ctrl: got %h want 08", d); else n_pass++;
        rd(5'h00, d); n_checks++; if (d !== 8'h02) $display("[TB] FAIL os_reload: got %h want 02", d); else n_pass++;
        phi_cycles(3);
        rd(5'h00, d); n_checks++; if (d !== 8'h02) $display("[TB] FAIL os_hold: got %h want 02", d); else n_pass++;
        rd(ICR, d);   n_checks++; if (d !== 8'h01) $display("[TB] FAIL os_icr: got %h want 01", d); else n_pass++;
        phi_cycles(3);
        rd(ICR, d);   n_checks++; if (d !== 8'h00) $display("[TB] FAIL os_icr2: got %h want 00", d); else n_pass++;
    endtask

    task automatic test_cascade();
        do_reset();
        wr(5'h00, 8'h01); wr(5'h01, 8'h00); wr(5'h08, 8'h02); wr(5'h09, 8'h00);
        wr(ICR, 8'h82); wr(5'h0C, 8'h41); wr(5'h04, 8'h01);
        phi_cycles(5);
        n_checks++; if (irq_n !== 1'b1) $display("[TB] FAIL cas_irq_pre: got %b want 1", irq_n); else n_pass++;
        step(1'b1);
        n_checks++; if (irq_n !== 1'b0) $display("[TB] FAIL cas_irq_uf: got %b want 0", irq_n); else n_pass++;
        rd(ICR, d);   n_checks++; if (d !== 8'h83) $display("[TB] FAIL cas_icr: got %h want 83", d); else n_pass++;
        rd(5'h00, d); n_checks++; if (d !== 8'h01) $display("[TB] FAIL cas_ch0: got %h want 01", d); else n_pass++;
        rd(5'h08, d); n_checks++; if (d !== 8'h02) $display("[TB] FAIL cas_ch1: got %h want 02", d); else n_pass++;
        step(1'b0);
        phi_cycles(5);
        n_checks++; if (irq_n !== 1'b1) $display("[TB] FAIL cas_irq_pre2: got %b want 1", irq_n); else n_pass++;
        step(1'b1);
        n_checks++; if (irq_n !== 1'b0) $display("[TB] FAIL cas_irq_uf2: got %b want 0", irq_n); else n_pass++;
    endtask

    task automatic test_outputs();
        do_reset();
        wr(5'h00, 8'h01); wr(5'h01, 8'h00); wr(5'h04, 8'h07);
        n_checks++; if (tmr_out !== 3'b001) $display("[TB] FAIL tgl_start: got %b want 001", tmr_out); else n_pass++;
        phi_cycles(1);
        n_checks++; if (tmr_out !== 3'b001) $display("[TB] FAIL tgl_t1: got %b want 001", tmr_out); else n_pass++;
        phi_cycles(1);
        n_checks++; if (tmr_out !== 3'b000) $display("[TB] FAIL tgl_uf1: got %b want 000", tmr_out); else n_pass++;
        phi_cycles(2);
        n_checks++; if (tmr_out !== 3'b001) $display("[TB] FAIL tgl_uf2: got %b want 001", tmr_out); else n_pass++;
        wr(5'h04, 8'h05);
        n_checks++; if (tmr_out !== 3'b000) $display("[TB] FAIL tgl_oe_off: got %b want 000", tmr_out); else n_pass++;
        do_reset();
        wr(5'h00, 8'h01); wr(5'h01, 8'h00); wr(5'h04, 8'h03);
        n_checks++; if (tmr_out !== 3'b000) $display("[TB] FAIL pls_start: got %b want 000", tmr_out); else n_pass++;
        phi_cycles(1);
        step(1'b1);
        n_checks++; if (tmr_out !== 3'b001) $display("[TB] FAIL pls_uf: got %b want 001", tmr_out); else n_pass++;
        step(1'b0);
        n_checks++; if (tmr_out !== 3'b001) $display("[TB] FAIL pls_hold: got %b want 001", tmr_out); else n_pass++;
        step(1'b1);
        n_checks++; if (tmr_out !== 3'b000) $display("[TB] FAIL pls_end: got %b want 000", tmr_out); else n_pass++;
    endtask

    task automatic test_icr_collision();
        do_reset();
        wr(5'h00, 8'h01); wr(5'h01, 8'h00); wr(ICR, 8'h81); wr(5'h04, 8'h01);
        phi_cycles(2);
        n_checks++; if (irq_n !== 1'b0) $display("[TB] FAIL col_irq: got %b want 0", irq_n); else n_pass++;
        rd(ICR, d); n_checks++; if (d !== 8'h81) $display("[TB] FAIL col_icr1: got %h want 81", d); else n_pass++;
        phi_cycles(1);
        rd_phi(ICR, d); n_checks++; if (d !== 8'h00) $display("[TB] FAIL col_old: got %h want 00", d); else n_pass++;
        n_checks++; if (irq_n !== 1'b0) $display("[TB] FAIL col_irq_new: got %b want 0", irq_n); else n_pass++;
        rd(ICR, d); n_checks++; if (d !== 8'h81) $display("[TB] FAIL col_icr2: got %h want 81", d); else n_pass++;
        n_checks++; if (irq_n !== 1'b1) $display("[TB] FAIL col_irq_clr: got %b want 1", irq_n); else n_pass++;
    endtask

    task automatic test_cnt_in();
        do_reset();
        wr(5'h00, 8'h03); wr(5'h01, 8'h00); wr(5'h04, 8'h21);
        phi_cycles(3);
        rd(5'h00, d); n_checks++; if (d !== 8'h03) $display("[TB] FAIL cnt_idle: got %h want 03", d); else n_pass++;
        cnt_in = 1'b1;
        step(1'b1);
        rd(5'h00, d); n_checks++; if (d !== 8'h03) $display("[TB] FAIL cnt_edge_smp: got %h want 03", d); else n_pass++;
        step(1'b1);
        rd(5'h00, d); n_checks++; if (d !== 8'h02) $display("[TB] FAIL cnt_tick: got %h want 02", d); else n_pass++;
        phi_cycles(3);
        rd(5'h00, d); n_checks++; if (d !== 8'h02) $display("[TB] FAIL cnt_level: got %h want 02", d); else n_pass++;
        cnt_in = 1'b0;
    endtask

    task automatic test_snapshot();
        do_reset();
        wr(5'h00, 8'h00); wr(5'h01, 8'h01); wr(5'h04, 8'h01);
        rd(5'h01, d); n_checks++; if (d !== 8'h01) $display("[TB] FAIL snap_msb: got %h want 01", d); else n_pass++;
        phi_cycles(3);
`ifdef TIMER_SNAPSHOT_EN
        rd(5'h00, d); n_checks++; if (d !== 8'h00) $display("[TB] FAIL snap_lsb: got %h want 00", d); else n_pass++;
        rd(5'h00, d); n_checks++; if (d !== 8'hFD) $display("[TB] FAIL snap_release: got %h want FD", d); else n_pass++;
`else
        rd(5'h00, d); n_checks++; if (d !== 8'hFD) $display("[TB] FAIL live_lsb: got %h want FD", d); else n_pass++;
`endif
    endtask

    initial begin
        $display("[TB] starting mos_timer_bank tests");
        test_reset();
        test_periodic();
        test_one_shot();
        test_cascade();
        test_outputs();
        test_icr_collision();
        test_cnt_in();
        test_snapshot();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
